// File: rtl/video_mode_detect_pkg.sv
// Shared video definitions: mode codes (`MODE_*), FSM state enum and the
// resolution classification table used by video_mode_detect.
`ifndef VIDEO_MODE_DEFINES
`define VIDEO_MODE_DEFINES
`define MODE_SIZE    3
`define MODE_UNKNOWN 3'd0
`define MODE_1080p   3'd1
`define MODE_1080i   3'd2
`define MODE_720p    3'd3
`define MODE_480p    3'd4
`define MODE_480i    3'd5
`define MODE_240p    3'd6
`endif

package video_mode_detect_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  typedef logic [`MODE_SIZE-1:0] mode_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic        il;
    mode_t       code;
  } mode_entry_t;

  localparam int NUM_MODES = 6;

  localparam mode_entry_t MODE_TABLE [NUM_MODES] = '{
    '{16'd1920, 16'd1080, 1'b0, `MODE_1080p},
    '{16'd1920, 16'd540,  1'b1, `MODE_1080i},
    '{16'd1280, 16'd720,  1'b0, `MODE_720p},
    '{16'd720,  16'd480,  1'b0, `MODE_480p},
    '{16'd720,  16'd240,  1'b1, `MODE_480i},
    '{16'd720,  16'd240,  1'b0, `MODE_240p}
  };

  localparam int HS_TIMEOUT_CLKS  = 4096;
  localparam int VS_TIMEOUT_LINES = 2048;

  // Table lookup; table dimensions are divided by h_div/v_div (1 for real timing).
  function automatic mode_t classify(input logic [15:0] h, input logic [15:0] v,
                                     input logic il, input logic incons,
                                     input int h_div, input int v_div);
    mode_t code;
    code = `MODE_UNKNOWN;
    if (!incons) begin
      for (int i = 0; i < NUM_MODES; i++) begin
        if (h == MODE_TABLE[i].h / 16'(h_div) &&
            v == MODE_TABLE[i].v / 16'(v_div) &&
            il == MODE_TABLE[i].il)
          code = MODE_TABLE[i].code;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/video_timing_measure.sv
// Line/field measurement: active pixels per line, active lines per field,
// field consistency, sync-loss timeouts and (with VIDEO_DETECT_INTERLACE_EN)
// vsync-to-hsync phase capture for interlace detection. Field results are
// combinational so they already include a line closing on the same cycle.
module video_timing_measure
  import video_mode_detect_pkg::*;
#(
  parameter int H_CNT_W = 12,
  parameter int V_CNT_W = 11
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               hsync,
  input  logic               vsync,
  input  logic               de,
  output logic               field_close,
  output logic [H_CNT_W-1:0] field_h,
  output logic [V_CNT_W-1:0] field_v,
  output logic               field_incons,
  output logic               field_il,
  output logic               sync_lost
);

  localparam logic [H_CNT_W-1:0] H_MAX = '1;
  localparam logic [V_CNT_W-1:0] V_MAX = '1;

  logic               hsync_q, vsync_q, hs_rise, vs_rise, line_close;
  logic [H_CNT_W-1:0] pix_cnt, first_len, first_next;
  logic [V_CNT_W-1:0] line_cnt, lines_next;
  logic               incons, incons_next;
  logic [12:0]        hs_idle;
  logic [11:0]        vs_idle;

  assign hs_rise    = hsync & ~hsync_q;
  assign vs_rise    = vsync & ~vsync_q;
  assign line_close = hs_rise && (pix_cnt != '0);

  // Fold a line closing on this cycle into the running field totals
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    lines_next  = line_cnt;
    first_next  = first_len;
    incons_next = incons;
    if (line_close) begin
      if (line_cnt != V_MAX) lines_next = line_cnt + 1'b1;
      if (line_cnt == '0) first_next = pix_cnt;
      else if (pix_cnt != first_len) incons_next = 1'b1;
    end
  end

  assign field_close  = vs_rise;
  assign field_h      = first_next;
  assign field_v      = lines_next;
  assign field_incons = incons_next;

  // Sync edge history, saturating pixel counter and per-field accumulators
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      first_len <= '0;
      incons    <= 1'b0;
    end else begin
      hsync_q <= hsync;
      vsync_q <= vsync;
      if (hs_rise) pix_cnt <= {{(H_CNT_W-1){1'b0}}, de};
      else if (de && pix_cnt != H_MAX) pix_cnt <= pix_cnt + 1'b1;
      if (vs_rise) begin
        line_cnt  <= '0;
        first_len <= '0;
        incons    <= 1'b0;
      end else begin
        line_cnt  <= lines_next;
        first_len <= first_next;
        incons    <= incons_next;
      end
    end
  end

  // Watchdogs: clocks since last hsync edge, lines since last vsync edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hs_idle <= '0;
      vs_idle <= '0;
    end else begin
      if (hs_rise) hs_idle <= '0;
      else if (hs_idle != 13'(HS_TIMEOUT_CLKS)) hs_idle <= hs_idle + 1'b1;
      if (vs_rise) vs_idle <= '0;
      else if (hs_rise && vs_idle != 12'(VS_TIMEOUT_LINES)) vs_idle <= vs_idle + 1'b1;
    end
  end

  assign sync_lost = (!hs_rise && hs_idle == 13'(HS_TIMEOUT_CLKS - 1)) ||
                     (hs_rise && !vs_rise && vs_idle == 12'(VS_TIMEOUT_LINES - 1));

`ifdef VIDEO_DETECT_INTERLACE_EN
  localparam int IL_DIFF_MIN = 16;

  logic [H_CNT_W-1:0] phase_cnt, phase_now, prev_phase, phase_diff;

  // A vsync coincident with hsync sits at phase 0
  assign phase_now  = hs_rise ? '0 : phase_cnt;
  assign phase_diff = (phase_now > prev_phase) ? phase_now - prev_phase
                                               : prev_phase - phase_now;
  assign field_il   = (phase_diff > H_CNT_W'(IL_DIFF_MIN));

  // Track hsync phase and remember it at every vsync edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_cnt  <= '0;
      prev_phase <= '0;
    end else begin
      if (hs_rise) phase_cnt <= {{(H_CNT_W-1){1'b0}}, 1'b1};
      else if (phase_cnt != H_MAX) phase_cnt <= phase_cnt + 1'b1;
      if (vs_rise) prev_phase <= phase_now;
    end
  end
`else
  assign field_il = 1'b0;
`endif

endmodule

// File: rtl/video_mode_detect.sv
// Video mode detector: classifies each measured field against the mode table
// and locks after STABLE_FRAMES identical known classifications. Interlace
// detection (1080i/480i) is built only with VIDEO_DETECT_INTERLACE_EN defined.
module video_mode_detect
  import video_mode_detect_pkg::*;
#(
  parameter int STABLE_FRAMES = 3,
  parameter int H_CNT_W       = 12,
  parameter int V_CNT_W       = 11,
  parameter int H_DIV         = 1,
  parameter int V_DIV         = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic                  de,
  output logic [`MODE_SIZE-1:0] mode_code,
  output logic                  mode_valid,
  output logic                  mode_changed,
  output logic [H_CNT_W-1:0]    h_active,
  output logic [V_CNT_W-1:0]    v_active,
  output logic                  interlaced
);

  localparam int MW = (STABLE_FRAMES < 2) ? 1 : $clog2(STABLE_FRAMES + 1);
  localparam logic [MW-1:0] MATCH_ONE = MW'(1);
  localparam logic [MW-1:0] LOCK_AT   = MW'(STABLE_FRAMES);

  logic               field_close, field_incons, field_il, sync_lost;
  logic [H_CNT_W-1:0] field_h;
  logic [V_CNT_W-1:0] field_v;
  state_t             state;
  mode_t              field_class, prev_class;
  logic [MW-1:0]      match_cnt, match_next;
  logic               known, lock_now;

  video_timing_measure #(
    .H_CNT_W (H_CNT_W),
    .V_CNT_W (V_CNT_W)
  ) u_measure (
    .clock        (clock),
    .reset_n      (reset_n),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .field_close  (field_close),
    .field_h      (field_h),
    .field_v      (field_v),
    .field_incons (field_incons),
    .field_il     (field_il),
    .sync_lost    (sync_lost)
  );

  assign field_class = classify(16'(field_h), 16'(field_v), field_il, field_incons,
                                H_DIV, V_DIV);
  assign known       = (field_class != `MODE_UNKNOWN);
  assign match_next  = (known && field_class == prev_class) ? match_cnt + 1'b1 : MATCH_ONE;
  assign lock_now    = known && (match_next == LOCK_AT);

  // SEARCH/MEASURE/LOCKED sequencing with registered mode outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= SEARCH;
      match_cnt    <= '0;
      prev_class   <= `MODE_UNKNOWN;
      mode_code    <= `MODE_UNKNOWN;
      mode_valid   <= 1'b0;
      mode_changed <= 1'b0;
      h_active     <= '0;
      v_active     <= '0;
      interlaced   <= 1'b0;
    end else begin
      mode_changed <= 1'b0;
      if (sync_lost) begin
        state      <= SEARCH;
        mode_valid <= 1'b0;
        match_cnt  <= '0;
        prev_class <= `MODE_UNKNOWN;
      end else if (field_close) begin
        unique case (state)
          SEARCH: begin
            // The field that ends here started before we were watching
            state      <= MEASURE;
            match_cnt  <= '0;
            prev_class <= `MODE_UNKNOWN;
          end
          MEASURE: begin
            prev_class <= field_class;
            match_cnt  <= match_next;
            if (lock_now) begin
              state        <= LOCKED;
              mode_code    <= field_class;
              h_active     <= field_h;
              v_active     <= field_v;
              interlaced   <= field_il;
              mode_valid   <= 1'b1;
              mode_changed <= 1'b1;
            end
          end
          LOCKED: begin
            if (field_class != mode_code) begin
              state      <= MEASURE;
              mode_valid <= 1'b0;
              match_cnt  <= MATCH_ONE;
              prev_class <= field_class;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed bench for video_mode_detect using table dimensions scaled by
// H_DIV=80 / V_DIV=60 (1920->24, 1280->16, 720->9; 1080->18, 720->12,
// 480->8, 540->9, 240->4). Lines are 40 clocks: hsync on clocks 0..3,
// de from clock 8. A field is one blank line carrying the vsync edge,
// v active lines, one trailing blank line.
module tb_video_mode_detect;
  import video_mode_detect_pkg::*;

  localparam int LINE_T = 40;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  hsync = 1'b0;
  logic                  vsync = 1'b0;
  logic                  de = 1'b0;
  logic [`MODE_SIZE-1:0] mode_code;
  logic                  mode_valid, mode_changed, interlaced;
  logic [11:0]           h_active;
  logic [10:0]           v_active;

  int   checks = 0;
  int   passed = 0;
  int   chg_count = 0;
  int   chg_base = 0;
  logic pre_valid, post_valid, post_chg, post2_chg;

  video_mode_detect #(
    .STABLE_FRAMES (3),
    .H_CNT_W       (12),
    .V_CNT_W       (11),
    .H_DIV         (80),
    .V_DIV         (60)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .hsync        (hsync),
    .vsync        (vsync),
    .de           (de),
    .mode_code    (mode_code),
    .mode_valid   (mode_valid),
    .mode_changed (mode_changed),
    .h_active     (h_active),
    .v_active     (v_active),
    .interlaced   (interlaced)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (mode_changed) chg_count++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic apply_reset();
    hsync = 1'b0;
    vsync = 1'b0;
    de = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // One field; records mode_valid just before/after the posedge seeing the vsync rise
  task automatic send_field(input int h, input int v, input int short_line, input int ph);
    for (int l = 0; l < v + 2; l++) begin
      for (int c = 0; c < LINE_T; c++) begin
        @(negedge clock);
        if (l == 0 && c == ph) pre_valid = mode_valid;
        if (l == 0 && c == ph + 1) begin
          post_valid = mode_valid;
          post_chg = mode_changed;
        end
        if (l == 0 && c == ph + 2) post2_chg = mode_changed;
        hsync = (c < 4);
        vsync = (l == 0 && c >= ph && c < ph + 8);
        de = (l >= 1 && l <= v && c >= 8 && c < 8 + ((l == short_line) ? h - 1 : h));
      end
    end
  endtask

  initial begin
    apply_reset();
    check("rst_mode_code", mode_code, `MODE_UNKNOWN);
    check("rst_mode_valid", mode_valid, 0);
    check("rst_mode_changed", mode_changed, 0);
    check("rst_h_active", h_active, 0);
    check("rst_v_active", v_active, 0);
    check("rst_interlaced", interlaced, 0);
    check("rst_state", dut.state, SEARCH);

    // 720p: lock on the 4th vsync edge (3rd complete field)
    chg_base = chg_count;
    for (int k = 0; k < 4; k++) begin
      send_field(16, 12, 0, 0);
      if (k == 2) check("720p_no_early_lock", post_valid, 0);
    end
    check("720p_valid_before_edge", pre_valid, 0);
    check("720p_valid_after_edge", post_valid, 1);
    check("720p_changed_pulse", post_chg, 1);
    check("720p_changed_one_cycle", post2_chg, 0);
    check("720p_mode_code", mode_code, `MODE_720p);
    check("720p_h_active", h_active, 16);
    check("720p_v_active", v_active, 12);
    check("720p_interlaced", interlaced, 0);
    check("720p_changed_count", chg_count - chg_base, 1);

    // Switch to 1080p: drop on first 1080p field, relock after 3
    send_field(24, 18, 0, 0);
    check("1080p_last_720p_field_keeps_lock", post_valid, 1);
    send_field(24, 18, 0, 0);
    check("1080p_drop_pre", pre_valid, 1);
    check("1080p_drop_post", post_valid, 0);
    check("1080p_code_held", mode_code, `MODE_720p);
    send_field(24, 18, 0, 0);
    check("1080p_still_measuring", post_valid, 0);
    send_field(24, 18, 0, 0);
    check("1080p_relock", post_valid, 1);
    check("1080p_changed_pulse", post_chg, 1);
    check("1080p_mode_code", mode_code, `MODE_1080p);
    check("1080p_not_interlaced", interlaced, 0);
    check("1080p_h_active", h_active, 24);
    check("1080p_v_active", v_active, 18);

    // 1920x540 fields, vsync alternating between line start and half line
    apply_reset();
    for (int k = 0; k < 5; k++) send_field(24, 9, 0, (k % 2 == 1) ? 20 : 0);
`ifdef VIDEO_DETECT_INTERLACE_EN
    check("1080i_valid", mode_valid, 1);
    check("1080i_mode_code", mode_code, `MODE_1080i);
    check("1080i_interlaced", interlaced, 1);
    check("1080i_v_active", v_active, 9);
`else
    check("1080i_no_lock", mode_valid, 0);
    check("1080i_interlaced_tied", interlaced, 0);
    check("1080i_mode_code", mode_code, `MODE_UNKNOWN);
`endif

    // 480p with one short line in the second field
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      send_field(9, 8, (k == 1) ? 4 : 0, 0);
      if (k == 3 || k == 4) check("short_line_no_lock", post_valid, 0);
    end
    check("480p_lock", post_valid, 1);
    check("480p_mode_code", mode_code, `MODE_480p);
    check("480p_h_active", h_active, 9);
    check("480p_v_active", v_active, 8);

    // Locked 480p, hsync stops: lock survives ~4000 clocks, lost by ~4140
    hsync = 1'b0;
    vsync = 1'b0;
    de = 1'b0;
    repeat (4000) @(negedge clock);
    check("hs_timeout_not_yet", mode_valid, 1);
    repeat (100) @(negedge clock);
    check("hs_timeout_valid", mode_valid, 0);
    check("hs_timeout_state", dut.state, SEARCH);

    // Reset mid-field while locked, then relock after 3 full fields
    apply_reset();
    for (int k = 0; k < 4; k++) send_field(16, 12, 0, 0);
    send_field(16, 5, 0, 0);
    check("pre_reset_locked", mode_valid, 1);
    @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", mode_valid, 0);
    check("async_rst_code", mode_code, `MODE_UNKNOWN);
    check("async_rst_h", h_active, 0);
    check("async_rst_v", v_active, 0);
    check("async_rst_state", dut.state, SEARCH);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    chg_base = chg_count;
    for (int k = 0; k < 4; k++) begin
      send_field(16, 12, 0, 0);
      if (k == 2) check("relock_not_after_2", post_valid, 0);
    end
    check("relock_valid", post_valid, 1);
    check("relock_changed_pulse", post_chg, 1);
    check("relock_changed_count", chg_count - chg_base, 1);
    check("relock_mode_code", mode_code, `MODE_720p);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
